// File: rtl/mode_sequencer.sv
// mode_sequencer: NUM_MODES-way system-mode controller.
// The lowest-numbered active set_req bit wins. Before a switch the controller
// drains the current datapath, optionally aborting on timeout. After a switch
// it holds off new requests for MIN_DWELL cycles.
// Optional feature macro: MODE_SEQ_LOCK_EN adds the mode_lock input. While
// mode_lock is 1 in STABLE, all requests are ignored.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   set_req       per-mode level requests (bit 0 = highest priority)
//   drain_ack     datapath idle, safe to leave the current mode
//   mode_lock     (MODE_SEQ_LOCK_EN only) blocks new switches in STABLE
//   mode          current system mode
//   target        mode being switched to (equals mode when idle)
//   drain_req     asks the datapath to drain the current mode
//   busy          switch in progress
//   mode_changed  1-cycle pulse, mode updated this cycle
//   timeout_err   1-cycle pulse, drain aborted on timeout
module mode_sequencer #(
  parameter int unsigned NUM_MODES     = 3,
  parameter int unsigned RESET_MODE    = 0,
  parameter int unsigned MIN_DWELL     = 4,
  parameter int unsigned DRAIN_TIMEOUT = 255,
  localparam int unsigned MW = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_MODES-1:0] set_req,
  input  logic                 drain_ack,
`ifdef MODE_SEQ_LOCK_EN
  input  logic                 mode_lock,
`endif
  output logic [MW-1:0]        mode,
  output logic [MW-1:0]        target,
  output logic                 drain_req,
  output logic                 busy,
  output logic                 mode_changed,
  output logic                 timeout_err
);

  localparam int unsigned DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
  localparam int unsigned TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [MW-1:0]   mode_nxt, target_nxt;
  logic            drain_req_nxt, busy_nxt, mode_changed_nxt, timeout_err_nxt;
  logic [DW-1:0]   dwell_cnt, dwell_nxt;
  logic [TW-1:0]   tmo_cnt, tmo_nxt;
  logic [MW-1:0]   decoded;
  logic            any_req;
  logic            lock;

`ifdef MODE_SEQ_LOCK_EN
  assign lock = mode_lock;
`else
  assign lock = 1'b0;
`endif

  // Fixed-priority decode: scanning downwards leaves the lowest set index.
  always_comb begin
    decoded = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (set_req[i]) decoded = MW'(i);
    end
  end

  assign any_req = |set_req;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt        = state;
    mode_nxt         = mode;
    target_nxt       = target;
    drain_req_nxt    = drain_req;
    busy_nxt         = busy;
    mode_changed_nxt = 1'b0;
    timeout_err_nxt  = 1'b0;
    dwell_nxt        = dwell_cnt;
    tmo_nxt          = tmo_cnt;
    case (state)
      ST_STABLE: begin
        if (dwell_cnt != '0) dwell_nxt = dwell_cnt - DW'(1);
        if (any_req && (decoded != mode) && (dwell_cnt == '0) && !lock) begin
          target_nxt    = decoded;
          drain_req_nxt = 1'b1;
          busy_nxt      = 1'b1;
          tmo_nxt       = '0;
          state_nxt     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // If ack and timeout occur on the same edge, ack wins.
        if (drain_ack) begin
          mode_nxt         = target;
          mode_changed_nxt = 1'b1;
          drain_req_nxt    = 1'b0;
          dwell_nxt        = DW'(MIN_DWELL);
          state_nxt        = ST_SETTLE;
        end else if ((DRAIN_TIMEOUT != 0) && (tmo_cnt == TW'(DRAIN_TIMEOUT - 1))) begin
          drain_req_nxt   = 1'b0;
          timeout_err_nxt = 1'b1;
          target_nxt      = mode;
          busy_nxt        = 1'b0;
          state_nxt       = ST_STABLE;
        end else if (tmo_cnt != '1) begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      ST_SETTLE: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_STABLE;
      end
      default: begin
        busy_nxt      = 1'b0;
        drain_req_nxt = 1'b0;
        target_nxt    = mode;
        state_nxt     = ST_STABLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_STABLE;
      mode         <= MW'(RESET_MODE);
      target       <= MW'(RESET_MODE);
      drain_req    <= 1'b0;
      busy         <= 1'b0;
      mode_changed <= 1'b0;
      timeout_err  <= 1'b0;
      dwell_cnt    <= '0;
      tmo_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      mode         <= mode_nxt;
      target       <= target_nxt;
      drain_req    <= drain_req_nxt;
      busy         <= busy_nxt;
      mode_changed <= mode_changed_nxt;
      timeout_err  <= timeout_err_nxt;
      dwell_cnt    <= dwell_nxt;
      tmo_cnt      <= tmo_nxt;
    end
  end

endmodule
